// File: rtl/side_servos_pkg.sv
// side_servos_pkg: register map, response codes, control bits and AXI FSM
// state types shared by the SideServos AXI4-Lite slave.
package side_servos_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LEFT   = 2'd1;
    localparam logic [1:0] REG_RIGHT  = 2'd2;
    localparam logic [1:0] REG_PERIOD = 2'd3;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam int CTRL_LEFT_EN  = 0;
    localparam int CTRL_RIGHT_EN = 1;

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_e;
    typedef enum logic {RD_IDLE, RD_RESP} rd_state_e;

endpackage

// File: rtl/side_servos_pwm.sv
// side_servos_pwm: shared-counter two-channel servo PWM whose settings are
// shadowed and reloaded only at period wrap, so pulses are never cut short.
module side_servos_pwm
    import side_servos_pkg::*;
#(
    parameter int C_PWM_WIDTH = 21
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [1:0]             i_ctrl,
    input  logic [C_PWM_WIDTH-1:0] i_left,
    input  logic [C_PWM_WIDTH-1:0] i_right,
    input  logic [C_PWM_WIDTH-1:0] i_period,
    output logic                   o_servo_left,
    output logic                   o_servo_right,
    output logic                   o_period_tick
);

    logic [1:0]             r_sh_ctrl;
    logic [C_PWM_WIDTH-1:0] r_sh_left;
    logic [C_PWM_WIDTH-1:0] r_sh_right;
    logic [C_PWM_WIDTH-1:0] r_sh_period;
    logic [C_PWM_WIDTH-1:0] r_cnt;
    logic                   w_run;
    logic                   w_wrap;
    logic                   w_load;

    assign w_run  = r_sh_period != '0;
    assign w_wrap = w_run && (r_cnt == r_sh_period - C_PWM_WIDTH'(1));
    // A zero period keeps the shadows transparent so a fresh PERIOD starts at once
    assign w_load = w_wrap || !w_run;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sh_ctrl     <= '0;
            r_sh_left     <= '0;
            r_sh_right    <= '0;
            r_sh_period   <= '0;
            r_cnt         <= '0;
            o_servo_left  <= 1'b0;
            o_servo_right <= 1'b0;
            o_period_tick <= 1'b0;
        end else begin
            if (w_load) begin
                r_sh_ctrl   <= i_ctrl;
                r_sh_left   <= i_left;
                r_sh_right  <= i_right;
                r_sh_period <= i_period;
            end
            r_cnt         <= w_load ? '0 : r_cnt + C_PWM_WIDTH'(1);
            o_servo_left  <= w_run && r_sh_ctrl[CTRL_LEFT_EN] && (r_cnt < r_sh_left);
            o_servo_right <= w_run && r_sh_ctrl[CTRL_RIGHT_EN] && (r_cnt < r_sh_right);
            o_period_tick <= w_run && (r_cnt == '0);
        end
    end

endmodule

// File: rtl/side_servos_axil_slave.sv
// side_servos_axil_slave: AXI4-Lite register file (CTRL, LEFT_PULSE,
// RIGHT_PULSE, PERIOD) driving the two-channel servo PWM generator.
module side_servos_axil_slave
    import side_servos_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int C_PWM_WIDTH        = 21
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            servo_left,
    output logic                            servo_right,
    output logic                            period_tick
);

    localparam int DW  = C_S_AXI_DATA_WIDTH;
    localparam int SW  = C_S_AXI_DATA_WIDTH / 8;

    logic [DW-1:0] r_regs [4];
    logic          r_aw_held;
    logic          r_w_held;
    logic [1:0]    r_aw_idx;
    logic [DW-1:0] r_w_data;
    logic [SW-1:0] r_w_strb;
    logic [DW-1:0] r_rdata;
    wr_state_e     r_wr_state;
    wr_state_e     w_wr_next;
    rd_state_e     r_rd_state;
    rd_state_e     w_rd_next;
    logic          w_aw_hs;
    logic          w_w_hs;
    logic          w_ar_hs;
    logic          w_do_write;
    logic [1:0]    w_wr_idx;
    logic [DW-1:0] w_wr_data;
    logic [SW-1:0] w_wr_strb;
    logic          w_unused;

    assign S_AXI_AWREADY = !r_aw_held && (r_wr_state == WR_IDLE);
    assign S_AXI_WREADY  = !r_w_held && (r_wr_state == WR_IDLE);
    assign S_AXI_BVALID  = r_wr_state == WR_RESP;
    assign S_AXI_BRESP   = RESP_OKAY;
    assign S_AXI_ARREADY = r_rd_state == RD_IDLE;
    assign S_AXI_RVALID  = r_rd_state == RD_RESP;
    assign S_AXI_RRESP   = RESP_OKAY;
    assign S_AXI_RDATA   = r_rdata;

    assign w_aw_hs    = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_w_hs     = S_AXI_WVALID && S_AXI_WREADY;
    assign w_ar_hs    = S_AXI_ARVALID && S_AXI_ARREADY;
    // Completes on the edge where the later of the two halves arrives
    assign w_do_write = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
    assign w_wr_idx   = r_aw_held ? r_aw_idx : S_AXI_AWADDR[3:2];
    assign w_wr_data  = r_w_held ? r_w_data : S_AXI_WDATA;
    assign w_wr_strb  = r_w_held ? r_w_strb : S_AXI_WSTRB;
    assign w_unused   = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_wr_state <= WR_IDLE;
            r_rd_state <= RD_IDLE;
        end else begin
            r_wr_state <= w_wr_next;
            r_rd_state <= w_rd_next;
        end
    end

    always_comb begin
        w_wr_next = r_wr_state;
        w_rd_next = r_rd_state;
        w_wr_next = (r_wr_state == WR_IDLE) ? (w_do_write ? WR_RESP : WR_IDLE)
                                            : (S_AXI_BREADY ? WR_IDLE : WR_RESP);
        w_rd_next = (r_rd_state == RD_IDLE) ? (w_ar_hs ? RD_RESP : RD_IDLE)
                                            : (S_AXI_RREADY ? RD_IDLE : RD_RESP);
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_idx  <= '0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_rdata   <= '0;
            for (int i = 0; i < 4; i++) r_regs[i] <= '0;
        end else begin
            if (w_do_write) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                for (int b = 0; b < SW; b++)
                    if (w_wr_strb[b]) r_regs[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_aw_idx  <= S_AXI_AWADDR[3:2];
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_w_data <= S_AXI_WDATA;
                    r_w_strb <= S_AXI_WSTRB;
                end
            end
            // Nonblocking read of r_regs returns the pre-write value on a collision
            if (w_ar_hs) r_rdata <= r_regs[S_AXI_ARADDR[3:2]];
        end
    end

    side_servos_pwm #(
        .C_PWM_WIDTH(C_PWM_WIDTH)
    ) u_pwm (
        .i_clk        (S_AXI_ACLK),
        .i_rst_n      (S_AXI_ARESETN),
        .i_ctrl       (r_regs[REG_CTRL][1:0]),
        .i_left       (r_regs[REG_LEFT][C_PWM_WIDTH-1:0]),
        .i_right      (r_regs[REG_RIGHT][C_PWM_WIDTH-1:0]),
        .i_period     (r_regs[REG_PERIOD][C_PWM_WIDTH-1:0]),
        .o_servo_left (servo_left),
        .o_servo_right(servo_right),
        .o_period_tick(period_tick)
    );

endmodule
